// File: rtl/qsys_system_nios2_01_cpu_debug_mem_arbiter.sv
// Debug-RAM arbiter: shares the CPU's single-port OCI debug RAM between JTAG
// debug commands (strobe + jdo) and the Avalon-MM debug_mem slave.
module qsys_system_nios2_01_cpu_debug_mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter bit JTAG_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {S_IDLE, S_JRD, S_JCAP, S_ARD, S_ACAP} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR} jop_t;

    state_t              state_q, state_d;
    jop_t                pend_op_q, pend_op_d, new_op;
    logic [DATA_W-1:0]   pend_wdata_q;
    logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
    logic                overrun_d, ready_d;
    logic                active_q, hist_vld_q, last_jtag_q;
    logic                jtag_req, avs_req, grant_jtag, grant_avs;
    logic                jstrobe, mon_load, avs_load, jrd_done;
    logic                jdo_unused;

    assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

    // active_q holds every grant off while reset is (or has just been) asserted,
    // so no RAM write can escape after reset_n falls.
    assign jtag_req = (pend_op_q != OP_NONE);
    assign avs_req  = active_q && (avs_read || avs_write);

    always_comb begin
        grant_jtag = 1'b0;
        grant_avs  = 1'b0;
        if (state_q == S_IDLE && active_q) begin
            if (jtag_req && avs_req) begin
                if (JTAG_PRIO)
                    grant_jtag = 1'b1;
                else if (!hist_vld_q || last_jtag_q)
                    grant_avs = 1'b1;
                else
                    grant_jtag = 1'b1;
            end else if (jtag_req) begin
                grant_jtag = 1'b1;
            end else if (avs_req) begin
                grant_avs = 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        ram_addr        = '0;
        ram_wr          = 1'b0;
        ram_wdata       = '0;
        avs_waitrequest = 1'b1;
        mon_load        = 1'b0;
        avs_load        = 1'b0;
        jrd_done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (grant_jtag) begin
                    ram_addr = jaddr_q;
                    if (pend_op_q == OP_WR) begin
                        ram_wr    = 1'b1;
                        ram_wdata = pend_wdata_q;
                    end else begin
                        state_d = S_JRD;
                    end
                end else if (grant_avs) begin
                    ram_addr = avs_address;
                    if (avs_write) begin
                        ram_wr          = 1'b1;
                        ram_wdata       = avs_writedata;
                        avs_waitrequest = 1'b0;
                    end else begin
                        state_d = S_ARD;
                    end
                end
            end
            S_JRD: begin
                mon_load = 1'b1;
                state_d  = S_JCAP;
            end
            S_JCAP: begin
                jrd_done = 1'b1;
                state_d  = S_IDLE;
            end
            S_ARD: begin
                avs_load = 1'b1;
                state_d  = S_ACAP;
            end
            S_ACAP: begin
                avs_waitrequest = 1'b0;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new strobe always replaces whatever is pending; the grant consumes the
    // pending op in the same cycle, so a strobe then is not an overrun.
    always_comb begin
        jstrobe = take_action_ocimem_a || take_action_ocimem_b || take_no_action_ocimem_a;
        new_op  = OP_NONE;
        if (take_action_ocimem_b)
            new_op = OP_WR;
        else if (take_no_action_ocimem_a || (take_action_ocimem_a && jdo[34]))
            new_op = OP_RD;

        pend_op_d = pend_op_q;
        if (grant_jtag)
            pend_op_d = OP_NONE;
        if (new_op != OP_NONE)
            pend_op_d = new_op;

        jaddr_d = jaddr_q;
        if ((grant_jtag && pend_op_q == OP_WR) || jrd_done)
            jaddr_d = jaddr_q + ADDR_W'(1);
        if (take_action_ocimem_a)
            jaddr_d = jdo[ADDR_W+16:17];

        overrun_d = jtag_overrun;
        if (jstrobe && jtag_req && !grant_jtag)
            overrun_d = 1'b1;
        else if (take_action_ocimem_a)
            overrun_d = 1'b0;

        ready_d = !((pend_op_d != OP_NONE) || state_d == S_JRD || state_d == S_JCAP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            pend_op_q     <= OP_NONE;
            jaddr_q       <= '0;
            active_q      <= 1'b0;
            hist_vld_q    <= 1'b0;
            last_jtag_q   <= 1'b0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            jtag_overrun  <= 1'b0;
            avs_readdata  <= '0;
        end else begin
            state_q       <= state_d;
            pend_op_q     <= pend_op_d;
            jaddr_q       <= jaddr_d;
            active_q      <= 1'b1;
            monitor_ready <= ready_d;
            jtag_overrun  <= overrun_d;
            if (grant_jtag || grant_avs) begin
                hist_vld_q  <= 1'b1;
                last_jtag_q <= grant_jtag;
            end
            if (mon_load)
                MonDReg <= ram_rdata;
            if (avs_load)
                avs_readdata <= ram_rdata;
        end
    end

    // Write payload only matters while an OP_WR is pending, so it needs no reset.
    always_ff @(posedge clk) begin
        if (take_action_ocimem_b)
            pend_wdata_q <= jdo[34:3];
    end

endmodule

// File: tb/tb_qsys_system_nios2_01_cpu_debug_mem_arbiter.sv
// Scoreboard bench for the debug-RAM arbiter: a behavioural RAM plus a reference
// memory/JTAG-address model predict every JTAG and Avalon read result.
module tb_qsys_system_nios2_01_cpu_debug_mem_arbiter;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [31:0]       MonDReg;
    logic              monitor_ready, jtag_overrun;
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read, avs_write;
    logic [31:0]       avs_writedata, avs_readdata;
    logic              avs_waitrequest;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [31:0]       ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    qsys_system_nios2_01_cpu_debug_mem_arbiter #(.ADDR_W(ADDR_W), .JTAG_PRIO(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .jtag_overrun(jtag_overrun),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural single-port RAM with one cycle of read latency
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_wr) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    int cyc = 0;
    int wr_in_reset = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n && ram_wr) wr_in_reset <= wr_in_reset + 1;
    end

    logic [31:0]       ref_mem [DEPTH];
    logic [ADDR_W-1:0] ref_jaddr;
    logic [32:0]       jq [$];
    logic [31:0]       aq [$];
    int n_cmp = 0;
    int n_fail = 0;
    int jdone_cyc = 0;
    int aack_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: pops a JTAG expectation on every monitor_ready rise and an
    // Avalon expectation on every acknowledged read.
    initial begin : monitor
        logic        prev_mr;
        logic [32:0] e;
        logic [31:0] a;
        prev_mr = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_mr = 1'b1;
            end else begin
                if (monitor_ready && !prev_mr) begin
                    jdone_cyc = cyc;
                    if (jq.size() == 0) report_fail("jtag_unexpected_completion");
                    else begin
                        e = jq.pop_front();
                        if (e[32]) check("jtag_MonDReg", MonDReg, e[31:0]);
                    end
                end
                prev_mr = monitor_ready;
                if (avs_read && !avs_waitrequest) begin
                    aack_cyc = cyc;
                    if (aq.size() == 0) report_fail("avs_unexpected_ack");
                    else begin
                        a = aq.pop_front();
                        check("avs_readdata", avs_readdata, a);
                    end
                end
            end
        end
    end

    // kind 0 = ocimem_a, 1 = ocimem_b, 2 = no_action_ocimem_a; one-cycle strobe
    task automatic jtag_strobe(input int kind, input logic [31:0] data,
                               input logic [ADDR_W-1:0] addr, input bit rd);
        @(posedge clk); #1;
        jdo = '0;
        if (kind == 0) begin
            jdo[ADDR_W+16:17] = addr;
            jdo[34] = rd;
            take_action_ocimem_a = 1'b1;
        end else if (kind == 1) begin
            jdo[34:3] = data;
            take_action_ocimem_b = 1'b1;
        end else begin
            take_no_action_ocimem_a = 1'b1;
        end
        @(posedge clk); #1;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_load(input logic [ADDR_W-1:0] addr, input bit rd);
        ref_jaddr = addr;
        if (rd) begin
            jq.push_back({1'b1, ref_mem[ref_jaddr]});
            ref_jaddr = ref_jaddr + 1'b1;
        end
        jtag_strobe(0, 32'h0, addr, rd);
    endtask

    task automatic jtag_write(input logic [31:0] data);
        ref_mem[ref_jaddr] = data;
        ref_jaddr = ref_jaddr + 1'b1;
        jq.push_back({1'b0, data});
        jtag_strobe(1, data, '0, 1'b0);
    endtask

    task automatic jtag_read();
        jq.push_back({1'b1, ref_mem[ref_jaddr]});
        ref_jaddr = ref_jaddr + 1'b1;
        jtag_strobe(2, 32'h0, '0, 1'b0);
    endtask

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (monitor_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) report_fail("monitor_ready_timeout");
    endtask

    task automatic avs_access(input bit wr, input logic [ADDR_W-1:0] addr,
                              input logic [31:0] data, output int stall);
        bit ok;
        @(posedge clk); #1;
        avs_address = addr;
        avs_writedata = data;
        avs_read = !wr;
        avs_write = wr;
        if (wr) ref_mem[addr] = data;
        else aq.push_back(ref_mem[addr]);
        stall = 0;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!avs_waitrequest) begin
                ok = 1'b1;
                break;
            end
            stall++;
        end
        if (!ok) report_fail("avs_waitrequest_timeout");
        @(posedge clk); #1;
        avs_read = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_MonDReg"}, MonDReg, 32'h0);
        check({tag, "_monitor_ready"}, 32'(monitor_ready), 32'h1);
        check({tag, "_jtag_overrun"}, 32'(jtag_overrun), 32'h0);
        check({tag, "_avs_readdata"}, avs_readdata, 32'h0);
        check({tag, "_avs_waitrequest"}, 32'(avs_waitrequest), 32'h1);
        check({tag, "_ram_wr"}, 32'(ram_wr), 32'h0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
        check({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        jq.delete();
        aq.delete();
        ref_jaddr = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int st, st2, d, j0;
        logic [ADDR_W-1:0] wa;
        logic [31:0] d1, d2;
        reset_n = 1'b1;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avs_address = '0;
        avs_read = 1'b0;
        avs_write = 1'b0;
        avs_writedata = '0;
        ref_jaddr = '0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Fill RAM through Avalon so every address has a known value
        for (int a = 0; a < DEPTH; a++) avs_access(1'b1, ADDR_W'(a), $urandom, st);
        check("avs_write_stall", st, 0);

        // Avalon write then read of 0x03
        avs_access(1'b1, 8'h03, 32'h55AA55AA, st);
        check("avs_wr_stall_0x03", st, 0);
        avs_access(1'b0, 8'h03, 32'h0, st);
        check("avs_rd_stall_0x03", st, 2);

        // JTAG load+read at 0x10, timing of MonDReg and monitor_ready
        avs_access(1'b1, 8'h10, 32'hDEADBEEF, st);
        jtag_load(8'h10, 1'b1);
        @(negedge clk);
        check("mr_fall_after_strobe", 32'(monitor_ready), 32'h0);
        repeat (2) @(negedge clk);
        check("MonDReg_3_cycles", MonDReg, 32'hDEADBEEF);
        wait_ready();
        jtag_read();
        wait_ready();

        // Write at 0xFF wraps the JTAG address
        jtag_load(8'hFF, 1'b0);
        @(negedge clk);
        check("mr_stays_on_load_only", 32'(monitor_ready), 32'h1);
        jtag_write(32'h12345678);
        wait_ready();
        avs_access(1'b0, 8'hFF, 32'h0, st);
        jtag_read();
        wait_ready();

        // Two ocimem_b strobes back to back while an Avalon read is in flight
        wa = ref_jaddr;
        d1 = 32'hC0FFEE01;
        d2 = 32'hC0FFEE02;
        fork
            avs_access(1'b0, 8'h40, 32'h0, st);
            begin
                @(posedge clk);
                @(posedge clk); #1;
                jdo = '0; jdo[34:3] = d1; take_action_ocimem_b = 1'b1;
                @(posedge clk); #1;
                jdo[34:3] = d2;
                @(posedge clk); #1;
                take_action_ocimem_b = 1'b0;
            end
        join
        ref_mem[wa] = d2;
        ref_jaddr = ref_jaddr + 1'b1;
        jq.push_back({1'b0, d2});
        wait_ready();
        check("overrun_set", 32'(jtag_overrun), 32'h1);
        avs_access(1'b0, wa, 32'h0, st);
        avs_access(1'b0, wa + 1'b1, 32'h0, st);
        jtag_read();
        wait_ready();
        check("overrun_sticky", 32'(jtag_overrun), 32'h1);
        jtag_load(8'h20, 1'b0);
        @(negedge clk);
        check("overrun_cleared", 32'(jtag_overrun), 32'h0);

        // Contention with no grant history: Avalon first
        apply_reset();
        fork
            jtag_load(8'h21, 1'b1);
            begin
                @(posedge clk);
                avs_access(1'b0, 8'h20, 32'h0, st);
            end
        join
        wait_ready();
        check("rr_avs_first_order", jdone_cyc - aack_cyc, 4);
        check("rr_avs_first_stall", st, 2);
        // Last grant becomes Avalon, so the next contention goes to JTAG
        avs_access(1'b1, 8'h30, $urandom, st2);
        fork
            jtag_load(8'h21, 1'b1);
            begin
                @(posedge clk);
                avs_access(1'b0, 8'h20, 32'h0, st);
            end
        join
        wait_ready();
        check("rr_jtag_first_order", jdone_cyc - aack_cyc, -2);
        check("rr_jtag_first_stall", st, 5);

        // Reset while a JTAG read sits in JRD
        jtag_load(8'h10, 1'b1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("reset_in_jrd");
        jq.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ref_jaddr = '0;
        @(posedge clk); #1;

        // Reset in the grant cycle of a JTAG write: the write must not land
        jtag_load(8'h50, 1'b0);
        wait_ready();
        jtag_strobe(1, 32'hBADC0DE5, '0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("abort_wr_ram_wr", 32'(ram_wr), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ref_jaddr = '0;
        @(posedge clk); #1;
        avs_access(1'b0, 8'h50, 32'h0, st);
        check("no_ram_write_in_reset", wr_in_reset, 0);

        // Randomised concurrent traffic: JTAG in 0x00-0x7F, Avalon in 0x80-0xFF
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    j0 = $urandom_range(0, 3);
                    if (ref_jaddr >= 8'h78 || j0 == 0)
                        jtag_load(ADDR_W'($urandom_range(0, 8'h70)), 1'($urandom_range(0, 1)));
                    else if (j0 == 1)
                        jtag_write($urandom);
                    else
                        jtag_read();
                    wait_ready();
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    avs_access(1'($urandom_range(0, 1)), ADDR_W'(8'h80 | $urandom_range(0, 127)), $urandom, d);
                    check("avs_stall_bound", 32'(d <= 5), 32'h1);
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                end
            end
        join

        repeat (4) @(posedge clk);
        check("jtag_queue_drained", jq.size(), 0);
        check("avs_queue_drained", aq.size(), 0);
        check("no_ram_write_in_reset_end", wr_in_reset, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
